// File: rtl/pipe_pkg.sv
// Shared types and helpers for the valid/allowin pipeline chain.
package pipe_pkg;

  localparam int STAGES_MAX = 8;

  // Handshake view of one stage, exported for checkers and debug.
  typedef struct packed {
    logic valid;
    logic allowin;
    logic ready_go;
    logic flush;
  } stage_hs_t;

  function automatic int unsigned popcount(input logic [STAGES_MAX-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < STAGES_MAX; i++) begin
      n = n + {31'b0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage: a valid bit plus DW-bit payload with allowin/flush control.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          to_valid,
  input  logic [DW-1:0] from_data,
  input  logic          ready_go,
  input  logic          flush,
  input  logic          next_allowin,
  output stage_hs_t     hs,
  output logic          valid_nxt,
  output logic [DW-1:0] data
);

  // Handshake: a payload moves from the previous stage into this one on a
  // rising edge exactly when to_valid && allowin; an empty stage always accepts.
  logic valid;
  logic allowin;

  assign allowin = !valid || (ready_go && next_allowin);

  always_comb begin
    valid_nxt = valid;
    if (flush) begin
      valid_nxt = 1'b0;
    end else if (allowin) begin
      valid_nxt = to_valid;
    end
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      valid <= valid_nxt;
      if (allowin && to_valid && !flush) begin
        data <= from_data;
      end
    end
  end

  assign hs = '{valid: valid, allowin: allowin, ready_go: ready_go, flush: flush};

endmodule

// File: rtl/pipe_ctrl_chain.sv
// In-order chain of STAGES handshaked stage registers with occupancy and bubble counters.
module pipe_ctrl_chain
  import pipe_pkg::*;
#(
  parameter int STAGES = 4,
  parameter int DW     = 64,
  parameter int CW     = 32
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         in_valid,
  input  logic [DW-1:0]                in_data,
  output logic                         in_allowin,
  input  logic [STAGES-1:0]            ready_go,
  input  logic [STAGES-1:0]            flush,
  input  logic                         out_allowin,
  output logic                         out_valid,
  output logic [DW-1:0]                out_data,
  output logic [STAGES-1:0]            stage_valid,
  output logic [STAGES*DW-1:0]         stage_data,
  output logic [$clog2(STAGES+1)-1:0]  occupancy,
  output logic [CW-1:0]                bubble_cnt
);

  localparam int OW = $clog2(STAGES+1);

  logic [STAGES-1:0] valid_nxt;

  // Each stage keeps its own allowin net so the out_allowin -> in_allowin
  // ripple is a plain chain of separate signals rather than one vector.
  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic          to_valid;
    logic [DW-1:0] from_data;
    logic          next_allowin;
    logic [DW-1:0] data;
    stage_hs_t     hs;

    if (i == 0) begin : g_head
      assign to_valid  = in_valid;
      assign from_data = in_data;
    end else begin : g_body
      assign to_valid  = g_stage[i-1].hs.valid && ready_go[i-1];
      assign from_data = g_stage[i-1].data;
    end

    if (i == STAGES-1) begin : g_tail
      assign next_allowin = out_allowin;
    end else begin : g_mid
      assign next_allowin = g_stage[i+1].hs.allowin;
    end

    pipe_stage_reg #(.DW(DW)) u_reg (
      .clk          (clk),
      .resetn       (resetn),
      .to_valid     (to_valid),
      .from_data    (from_data),
      .ready_go     (ready_go[i]),
      .flush        (flush[i]),
      .next_allowin (next_allowin),
      .hs           (hs),
      .valid_nxt    (valid_nxt[i]),
      .data         (data)
    );

    assign stage_valid[i]          = hs.valid;
    assign stage_data[i*DW +: DW]  = data;
  end

  assign in_allowin = g_stage[0].hs.allowin;
  assign out_valid  = g_stage[STAGES-1].hs.valid && ready_go[STAGES-1];
  assign out_data   = g_stage[STAGES-1].data;

  // Occupancy is counted from the next-state vector so it tracks stage_valid exactly.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      occupancy  <= '0;
      bubble_cnt <= '0;
    end else begin
      occupancy <= OW'(popcount(STAGES_MAX'(valid_nxt)));
      if (!out_valid && !(&bubble_cnt)) begin
        bubble_cnt <= bubble_cnt + CW'(1);
      end
    end
  end

endmodule

// File: doc/pipe_ctrl_chain.md
Name: pipe_ctrl_chain

Overview:
Parametrised in-order pipeline skeleton for the CPU datapath. It replaces the hand-written, always-advancing stage registers with a chain of STAGES valid/allowin handshaked stage registers, each carrying a DW-bit payload.
- Per-stage stall (ready_go) and per-stage flush.
- Occupancy and bubble counters for performance measurement.
- Sits between instruction fetch (upstream producer) and write-back (downstream consumer).

Parameters:
STAGES, 4, number of stage registers in the chain (2..8)
DW, 64, payload width per stage in bits
CW, 32, width of the bubble counter

Ports:
clk  in  1  clock, rising edge
resetn  in  1  reset, asynchronous, active-high
in_valid  in  1  upstream presents a payload
in_data  in  DW  upstream payload
in_allowin  out  1  stage 0 accepts this cycle
ready_go  in  STAGES  bit i: stage i has finished its work and may pass its payload on
flush  in  STAGES  bit i: kill the payload in stage i
out_allowin  in  1  downstream accepts the last stage's payload
out_valid  out  1  last stage valid && ready_go[STAGES-1]
out_data  out  DW  last stage payload
stage_valid  out  STAGES  valid bit of each stage
stage_data  out  STAGES*DW  payload of each stage; stage i occupies bits [i*DW +: DW]
occupancy  out  $clog2(STAGES+1)  number of valid stages
bubble_cnt  out  CW  cycles in which out_valid was 0

Behaviour:
- Reset (asynchronous, resetn=1):
  - all stage_valid=0, all stage_data=0, bubble_cnt=0, occupancy=0.
  - out_valid=0, in_allowin=1 (combinational consequence).
- Definitions:
  - allowin[STAGES] = out_allowin.
  - allowin[i] = !valid[i] || (ready_go[i] && allowin[i+1]).
  - in_allowin = allowin[0].
  - Stage -1 is in_valid with ready_go = 1.
  - to_valid[i] = valid[i-1] && ready_go[i-1].
- Per stage i, on posedge, in priority order:
  1. flush[i] -> valid[i] <= 0; data unchanged.
  2. else if allowin[i] -> valid[i] <= to_valid[i].
  3. else hold.
- Data capture: data[i] <= data[i-1] (in_data for i=0) only when allowin[i] && to_valid[i] && !flush[i]. Otherwise data holds.
- A stage whose valid is 0 always accepts (bubble collapse): a stall at stage k does not block stages <k that hold bubbles.
- Flush vs move:
  - Flushing stage i does not affect stage i+1 capturing the old content of stage i in the same cycle.
  - The caller asserts flush on both stages if both must die.
  - Typical branch flush is a mask of all stages younger than the branch.
- Latency: an unstalled payload appears at out_valid STAGES cycles after acceptance (in_valid && in_allowin). Throughput is 1 per cycle.
- Combinational path: out_allowin -> in_allowin ripples through all stages. There is no register on this path; this is intentional.
- out_valid/out_data are combinational from the last stage and ready_go[STAGES-1].
- occupancy is the registered popcount of the next-state valid vector, so it equals popcount(stage_valid) every cycle.
- bubble_cnt increments when out_valid==0 and saturates at all-ones.
- Reset mid-operation clears everything immediately, regardless of clock.
- X-safety: in_data/ready_go are don't-care when the corresponding valid is 0 and must not affect any output except stage_data.

Decomposition:
- Shared package pipe_pkg:
  - STAGES_MAX = 8.
  - Function popcount.
  - Typedef for the per-stage handshake bundle {valid, allowin, ready_go, flush}.
- One natural sub-module: pipe_stage_reg, a single valid+DW-bit payload register with the allowin/flush logic above.
- pipe_ctrl_chain instantiates pipe_stage_reg in a generate loop and adds the occupancy and bubble counter logic.

Test Plan:
1. Reset then stream: STAGES=4, in_valid=1, in_data=1,2,3..., all ready_go=1, out_allowin=1 -> in_allowin=1 every cycle; out_data=1 on cycle 4 after the first accept, then 2,3,... consecutively; occupancy=4 in steady state.
2. Mid stall: ready_go[2]=0 for 3 cycles while streaming -> stages 0..2 hold, stage 3 drains. in_allowin drops in the cycle stage 1 is full and stage 2 is stalled; no payload lost or duplicated, output order preserved.
3. Bubble collapse: single payload 0xA5 then in_valid=0; hold ready_go[3]=0; inject 0x5A -> 0x5A advances to stage 2 and stops. Both payloads exit in order once ready_go[3]=1.
4. Flush: stages 0..3 hold 10,11,12,13; assert flush=4'b0011 with out_allowin=0 and ready_go[3]=0 -> next cycle stage_valid=4'b1100, occupancy=2, out_data remains 13.
5. Back-pressure plus flush on the same cycle: flush[1] while stage 2 accepts from stage 1 -> stage 2 holds the old stage-1 payload and is valid; stage 1 is invalid.
6. Asynchronous reset pulse mid-stream (between clock edges) -> stage_valid=0 and bubble_cnt=0 immediately. With CW=4 and an idle pipe, bubble_cnt saturates at 15.
